pif_led_fader: RTL and testbench
================================

# pif_led_fader

Parametrised multi-channel LED driver for the PIF board status LEDs. Each channel is driven in one of four modes: off, on, sigma-delta "breathing" (a triangle-wave brightness ramp), or blink. Channels share one tick divider and ramp but are staggered in phase. It sits between the board oscillator clock domain and the LED pins, and replaces the fixed two-colour flasher with a runtime-configurable block.

## Interface
- `NUM_CH`, default 2: number of LED channels; legal range 1..8.
- `B`, default 5: brightness resolution in bits; the ramp is B+1 bits; legal range 2..12.
- `TICK_DIV`, default 8: clock cycles per ramp tick; legal range 2..65535. The divider counter is $clog2(TICK_DIV) bits wide.
- `ACTIVE_LOW`, default 1: when 1, a lit LED drives the pin 0.

- `Clk`  in  1: single clock (board oscillator).
- `RstN`  in  1: asynchronous, active-low reset.
- `CfgLoad`  in  1: single-cycle strobe; loads `ModeIn` and restarts the ramp.
- `ModeIn`  in  2*NUM_CH: per-channel mode; bits [2i+1:2i] belong to channel i. 00 = off, 01 = on, 10 = breathe, 11 = blink.
- `Led`  out  NUM_CH: LED pin drives, registered.
- `Tick`  out  1: one-cycle pulse per tick, decoded from state.
- `Wrap`  out  1: one-cycle pulse on the tick where the ramp rolls over.

## Operation
- **Divider.** `DivCnt` counts 0..TICK_DIV-1 and then wraps to 0.
  - Internal `TickI` = (DivCnt == TICK_DIV-1) && !CfgLoad.
  - `Tick` output = `TickI`.
- **Ramp.** `Ramp` is B+1 bits and increments by 1 on `TickI`, modulo 2^(B+1).
  - `Wrap` = TickI && (Ramp == all ones).
- **Channel phase.** `OFFSET` = 2^(B+1) / NUM_CH, truncated.
  - Channel ramp: `R_i` = (Ramp + i*OFFSET) mod 2^(B+1).
  - Direction: `Dir_i` = R_i[B].
  - Level: `L_i` = Dir_i ? ~R_i[B-1:0] : R_i[B-1:0], B bits. This gives a triangle wave: 0 rising to 2^B-1, then falling back.
- **Sigma-delta.** Each channel has a B+1-bit accumulator `Acc_i`.
  - On `TickI` or `CfgLoad`: Acc_i <= 0.
  - Otherwise: Acc_i <= {1'b0, Acc_i[B-1:0]} + {1'b0, L_i}.
  - `Sd_i` <= Acc_i[B] every cycle (registered).
- **Lit decode.** `Lit_i` depends on the mode register `Mode_i`:
  - off → 0
  - on → 1
  - breathe → `Sd_i`
  - blink → `Dir_i`
- **Output.** `Led[i]` <= Lit_i ^ ACTIVE_LOW, registered.
- **CfgLoad.** In the same cycle: Mode_i <= ModeIn; DivCnt, Ramp, all Acc_i and all Sd_i are cleared. `Led` reflects the new mode on the following edge.
- **Reset.** While RstN = 0, all of the following are held at zero:
  - Mode_i (all channels off), DivCnt, Ramp, Acc_i, Sd_i.
  - Led = {NUM_CH{ACTIVE_LOW}}, i.e. all dark.
  - Tick = 0 and Wrap = 0, since DivCnt = 0 ≠ TICK_DIV-1.

## Timing
- Tick period is exactly TICK_DIV cycles; the first `Tick` comes TICK_DIV-1 cycles after reset release or after `CfgLoad`.
- Ramp period is 2^(B+1) ticks; `Wrap` fires once per period, coincident with `Tick`.
- Mode change latency: `CfgLoad` sampled at edge k, Mode updated at k, `Led` updated at k+1.
- Breathe path latency: L_i change → Acc_i (1 cycle) → Sd_i (1 cycle) → Led (1 cycle). This is 3 cycles, constant for every channel.
- Duty within one tick: with constant level L, lit cycles ≈ floor((TICK_DIV-1)*L / 2^B), ±1 because of pipeline alignment across the tick boundary.
  - L = 0 gives 0 lit cycles.
  - L = 2^B-1 gives at least TICK_DIV-3 lit cycles.
- **Simultaneous CfgLoad and divider terminal count.** CfgLoad wins: Ramp is not incremented, and `Tick`/`Wrap` stay low.
- **CfgLoad held for several cycles.** The block stays frozen with Ramp = 0; the last `ModeIn` sampled is used.
- **Reset asserted mid-ramp.** Led goes dark asynchronously, without waiting for a clock edge. Ramp restarts from 0 after release.
- **NUM_CH = 1.** OFFSET = 2^(B+1), which reduces mod 2^(B+1) to 0 offset.
- **Ramp wrap.** Wrap from all-ones to 0 is seamless. Level is continuous across the wrap: the falling edge reaches 0 at Ramp = 2^(B+1)-1, and the next value after the wrap is 0.

## Test plan
- **Reset.** Defaults with ACTIVE_LOW = 1, NUM_CH = 2, B = 5, TICK_DIV = 8. Hold RstN = 0 for 5 cycles, release.
  - Led = 2'b11 throughout; Tick = 0 for 7 cycles; first Tick on cycle 8 after release.
- **Static modes.** CfgLoad with ModeIn = 4'b0100 (ch0 off, ch1 on).
  - One cycle later: Led[1] = 0 (lit) and Led[0] = 1, held indefinitely.
- **Blink and Wrap.** ModeIn = 4'b1111, TICK_DIV = 8.
  - Wrap pulses every 512 cycles.
  - Led[0] toggles every 256 cycles.
  - Led[1] is offset by 32 ticks (256 cycles), i.e. in antiphase with Led[0].
- **Breathe duty.** B = 5, TICK_DIV = 32, breathe on ch0. Count lit cycles per tick:
  - tick with L = 0: 0 lit cycles;
  - tick with L = 16: 15 ±1 lit cycles;
  - tick with L = 31: at least 29 lit cycles.
  - The sequence of counts must be monotonic up and then down over one ramp period.
- **Collision.** Assert CfgLoad exactly when DivCnt = TICK_DIV-1.
  - Tick = 0 and Wrap = 0 in that cycle; Ramp remains 0; next Tick comes TICK_DIV-1 cycles later.
- **Mid-operation reset.** Pulse RstN low for 1 ns during breathe mode at Ramp = 40.
  - Led goes to all 1s immediately; after release all modes are off and Ramp = 0.

Source files
------------

// File: rtl/pif_led_fader.sv
// Multi-channel status LED driver: off / on / sigma-delta breathe / blink per channel,
// sharing one tick divider and triangle ramp with per-channel phase stagger.
module pif_led_fader #(
   parameter int NUM_CH     = 2,
   parameter int B          = 5,
   parameter int TICK_DIV   = 8,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                  Clk,
   input  logic                  RstN,
   input  logic                  CfgLoad,
   input  logic [2*NUM_CH-1:0]   ModeIn,
   output logic [NUM_CH-1:0]     Led,
   output logic                  Tick,
   output logic                  Wrap
);

   localparam int DW     = $clog2(TICK_DIV);
   localparam int RW     = B + 1;
   localparam int OFFSET = (2 ** RW) / NUM_CH;

   typedef enum logic [1:0] {
      MODE_OFF     = 2'b00,
      MODE_ON      = 2'b01,
      MODE_BREATHE = 2'b10,
      MODE_BLINK   = 2'b11
   } mode_t;

   logic [DW-1:0]     div_cnt;
   logic [RW-1:0]     ramp;
   logic              tick_i;
   logic [NUM_CH-1:0] lit;

   // CfgLoad suppresses the tick so a colliding load never advances the ramp
   assign tick_i = (div_cnt == DW'(TICK_DIV - 1)) && !CfgLoad;
   assign Tick   = tick_i;
   assign Wrap   = tick_i && (ramp == '1);

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         div_cnt <= '0;
         ramp    <= '0;
      end else if (CfgLoad) begin
         div_cnt <= '0;
         ramp    <= '0;
      end else begin
         if (div_cnt == DW'(TICK_DIV - 1))
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + DW'(1);
         if (tick_i)
            ramp <= ramp + RW'(1);
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [RW-1:0] CH_OFS = RW'((gi * OFFSET) % (2 ** RW));

      mode_t         mode;
      logic [RW-1:0] acc;
      logic [RW-1:0] r;
      logic          sd;
      logic          dir;
      logic [B-1:0]  lvl;
      logic          lit_ch;

      assign r   = ramp + CH_OFS;
      assign dir = r[B];
      assign lvl = dir ? ~r[B-1:0] : r[B-1:0];

      always_ff @(posedge Clk or negedge RstN) begin
         if (!RstN) begin
            mode <= MODE_OFF;
            acc  <= '0;
            sd   <= 1'b0;
         end else if (CfgLoad) begin
            mode <= mode_t'(ModeIn[2*gi +: 2]);
            acc  <= '0;
            sd   <= 1'b0;
         end else begin
            if (tick_i)
               acc <= '0;
            else
               acc <= {1'b0, acc[B-1:0]} + {1'b0, lvl};
            sd <= acc[B];
         end
      end

      always_comb begin
         lit_ch = 1'b0;
         unique case (mode)
            MODE_OFF:     lit_ch = 1'b0;
            MODE_ON:      lit_ch = 1'b1;
            MODE_BREATHE: lit_ch = sd;
            MODE_BLINK:   lit_ch = dir;
            default:      lit_ch = 1'b0;
         endcase
      end

      assign lit[gi] = lit_ch;
   end

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN)
         Led <= {NUM_CH{ACTIVE_LOW}};
      else
         Led <= lit ^ {NUM_CH{ACTIVE_LOW}};
   end

endmodule

// File: tb/tb_pif_led_fader.sv
// Directed bench for pif_led_fader: default instance (TICK_DIV=8) for reset, static,
// blink, wrap and collision checks; TICK_DIV=32 instance for breathe duty and mid-run reset.
module tb_pif_led_fader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_a, cfg_b;
   logic [3:0] mode_a, mode_b;
   logic [1:0] led_a, led_b;
   logic       tick_a, tick_b, wrap_a, wrap_b;

   int n_cmp = 0;
   int n_bad = 0;
   int cnt [64];

   always #5 clk = ~clk;

   pif_led_fader dut_a (
      .Clk(clk), .RstN(rst_n), .CfgLoad(cfg_a), .ModeIn(mode_a),
      .Led(led_a), .Tick(tick_a), .Wrap(wrap_a)
   );

   pif_led_fader #(.TICK_DIV(32)) dut_b (
      .Clk(clk), .RstN(rst_n), .CfgLoad(cfg_b), .ModeIn(mode_b),
      .Led(led_b), .Tick(tick_b), .Wrap(wrap_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cfg_a = 1'b0; cfg_b = 1'b0; mode_a = '0; mode_b = '0;

      // reset held for 5 cycles
      for (int i = 0; i < 5; i++) begin
         step();
         check("rst_led_a", led_a, 2'b11);
         check("rst_led_b", led_b, 2'b11);
         check("rst_tick", tick_a, 0);
         check("rst_wrap", wrap_a, 0);
      end
      rst_n = 1'b1;
      #1;
      check("rel_tick0", tick_a, 0);
      for (int k = 1; k <= 7; k++) begin
         step();
         check("rel_tick", tick_a, (k == 7) ? 1 : 0);
         check("rel_led", led_a, 2'b11);
      end

      // static: ch0 off, ch1 on
      step();
      cfg_a = 1'b1; mode_a = 4'b0100;
      step();
      cfg_a = 1'b0;
      check("static_led_lat", led_a, 2'b11);
      step();
      check("static_led", led_a, 2'b01);
      for (int i = 0; i < 20; i++) begin
         step();
         check("static_hold", led_a, 2'b01);
      end

      // blink on both channels
      cfg_a = 1'b1; mode_a = 4'b1111;
      step();
      cfg_a = 1'b0;
      for (int n = 1; n <= 1100; n++) begin
         step();
         check("blink_led", led_a, (((n - 1) / 256) % 2 == 0) ? 2'b01 : 2'b10);
         check("blink_wrap", wrap_a, (n == 511 || n == 1023) ? 1 : 0);
         check("blink_tick", tick_a, (n % 8 == 7) ? 1 : 0);
      end

      // collision with terminal count, CfgLoad held three cycles
      step(); step(); step();
      cfg_a = 1'b1; mode_a = 4'b1111;
      #1;
      check("coll_tick", tick_a, 0);
      check("coll_wrap", wrap_a, 0);
      step();
      mode_a = 4'b0000;
      check("hold_ramp1", dut_a.ramp, 0);
      check("hold_tick1", tick_a, 0);
      step();
      mode_a = 4'b0100;
      check("hold_ramp2", dut_a.ramp, 0);
      step();
      cfg_a = 1'b0;
      check("hold_ramp3", dut_a.ramp, 0);
      for (int k = 1; k <= 7; k++) begin
         step();
         check("coll_next_tick", tick_a, (k == 7) ? 1 : 0);
         if (k == 1) check("hold_last_mode", led_a, 2'b01);
      end

      // breathe duty on dut_b ch0
      cfg_b = 1'b1; mode_b = 4'b0010;
      step();
      cfg_b = 1'b0;
      step(); step();
      for (int k = 0; k < 64; k++) begin
         cnt[k] = 0;
         for (int j = 0; j < 32; j++) begin
            if (led_b[0] == 1'b0) cnt[k]++;
            step();
         end
      end
      check("breathe_l0", cnt[0], 0);
      check("breathe_l16_lo", (cnt[16] >= 14) ? 1 : 0, 1);
      check("breathe_l16_hi", (cnt[16] <= 16) ? 1 : 0, 1);
      check("breathe_l31", (cnt[31] >= 29) ? 1 : 0, 1);
      check("breathe_ch1_off", led_b[1], 1);
      for (int k = 0; k < 64; k++) begin
         int lv, ex;
         lv = (k < 32) ? k : 63 - k;
         ex = (31 * lv) / 32;
         check("breathe_duty", (cnt[k] >= ex - 1 && cnt[k] <= ex + 1) ? 1 : 0, 1);
      end
      for (int k = 0; k < 31; k++)
         check("breathe_rise", (cnt[k + 1] >= cnt[k]) ? 1 : 0, 1);
      for (int k = 32; k < 63; k++)
         check("breathe_fall", (cnt[k + 1] <= cnt[k]) ? 1 : 0, 1);

      // mid-run reset at ramp 40
      for (int i = 0; i < 1290; i++) step();
      check("pre_rst_ramp", dut_b.ramp, 40);
      rst_n = 1'b0;
      #1;
      check("async_led_b", led_b, 2'b11);
      check("async_led_a", led_a, 2'b11);
      rst_n = 1'b1;
      #1;
      check("post_rst_ramp", dut_b.ramp, 0);
      for (int k = 1; k <= 40; k++) begin
         step();
         check("post_rst_led_b", led_b, 2'b11);
         check("post_rst_led_a", led_a, 2'b11);
         if (k <= 7) check("post_rst_tick", tick_a, (k == 7) ? 1 : 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
